my_pc_stack_16: RTL and testbench
=================================

// Module: my_pc_stack_16
// PURPOSE
//   16-bit program counter with a hardware return-address stack for the CPU fetch path.
//   Next-sequential address comes from an internal my_incrementer_16 instance (out+1).
//   Supports load/jump, call (push out+1, jump) and return (pop into PC).
//   Drives the instruction-memory address bus.
// PARAMETERS
//   DEPTH       4        return-stack entries, >=1; sp is $clog2(DEPTH+1) bits
//   RESET_ADDR  16'h0000 PC value after reset
// PORTS
//   clk    input   1   single clock; all state updates on rising edge
//   reset  input   1   synchronous, active-high reset
//   out    output  16  current PC, registered
//   in     input   16  jump/call target address
//   load   input   1   jump: PC <= in
//   inc    input   1   advance: PC <= out+1
//   call   input   1   push out+1, PC <= in
//   ret    input   1   pop: PC <= top of stack
//   full   output  1   sp == DEPTH, combinational from sp register
//   empty  output  1   sp == 0, combinational from sp register
//   err    output  1   sticky overflow/underflow flag, registered
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high.
//   - Reset: out=RESET_ADDR, sp=0 (empty=1, full=0), err=0. Stack RAM contents are don't-care.
//   - Reset applied mid-sequence discards all pending stack state the same cycle.
//   - Priority per cycle: reset > ret > call > load > inc > hold.
//     - Only the highest-priority asserted control acts.
//     - Lower-priority controls have no effect on out, sp or err that cycle.
//   - Latency: one cycle. Controls sampled at edge N; out/full/empty/err valid after edge N.
//   - hold (no control): out, sp and err unchanged.
//   - inc: out <= out+1 via my_incrementer_16. Wraps: 16'hFFFF -> 16'h0000, no flag.
//   - load: out <= in.
//   - call, not full:
//     - stack[sp] <= out+1 (wrapped), sp <= sp+1, out <= in.
//     - call at 16'hFFFF pushes 16'h0000.
//   - call, full (overflow):
//     - out <= in (jump still taken); push dropped; sp unchanged; err <= 1.
//     - Oldest entries are never overwritten: no circular wrap.
//   - ret, not empty: out <= stack[sp-1], sp <= sp-1.
//   - ret, empty (underflow): out unchanged, sp unchanged, err <= 1.
//   - call+ret same cycle: ret acts, call ignored; an empty stack gives underflow per above.
//   - err is sticky: set by any overflow/underflow, cleared only by reset.
//   - No combinational path from any input to out; full/empty depend on sp only.
// TESTING
//   1. reset=1 for 1 cycle -> out=0000, empty=1, full=0, err=0.
//      Then inc x3 -> out=0003.
//   2. load in=FFFE; inc x2 -> out=FFFF then 0000 (wrap); err stays 0.
//   3. DEPTH=4, out=0010:
//      - call in=0100 -> out=0100, sp=1.
//      - call in=0200 -> out=0200.
//      - ret -> out=0101.
//      - ret -> out=0011, empty=1.
//   4. Four calls fill the stack (full=1).
//      - 5th call in=0ABC -> out=0ABC, sp stays 4, err=1.
//      - Four rets return the correct four addresses in LIFO order.
//   5. From reset, ret -> out unchanged, err=1.
//      Then load+inc+call+ret all asserted with empty stack -> underflow path only; out unchanged.
//   6. out=0050 with 2 entries pushed, err=1; assert reset with call=1
//      -> out=0000, sp=0, err=0; the call is not performed.

Source files
------------

// File: rtl/my_pc_stack_16.sv
// Fetch-path program counter with a bounded hardware return-address stack.
// A small 16-bit incrementer supplies the next sequential address (out+1).

module my_incrementer_16 (
  input  logic [15:0] a,
  output logic [15:0] y
);
  // Plain modular add: FFFF wraps to 0000 with no carry out.
  assign y = a + 16'd1;
endmodule

module my_pc_stack_16 #(
  parameter int unsigned        DEPTH      = 4,
  parameter logic [15:0]        RESET_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        inc,
  input  logic        call,
  input  logic        ret,
  output logic [15:0] out,
  output logic        full,
  output logic        empty,
  output logic        err
);
  localparam int unsigned SPW  = $clog2(DEPTH + 1);
  localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0]     pc_q, pc_d;
  logic [15:0]     pc_inc;
  logic [SPW-1:0]  sp_q, sp_d;
  logic            err_q, err_d;
  logic            push_en;
  logic [IDXW-1:0] push_idx;
  logic [IDXW-1:0] pop_idx;
  logic [15:0]     stack_mem [DEPTH];

  my_incrementer_16 u_inc (
    .a (pc_q),
    .y (pc_inc)
  );

  // push_idx is only used when sp < DEPTH, pop_idx only when sp > 0.
  assign push_idx = IDXW'(sp_q);
  assign pop_idx  = IDXW'(sp_q - 1'b1);

  assign full  = (sp_q == SPW'(DEPTH));
  assign empty = (sp_q == '0);

  // Single-winner priority: ret > call > load > inc > hold. Reset is applied
  // in the register process and overrides everything decided here.
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push_en = 1'b0;
    if (ret) begin
      if (empty) begin
        err_d = 1'b1;
      end else begin
        pc_d = stack_mem[pop_idx];
        sp_d = sp_q - 1'b1;
      end
    end else if (call) begin
      // The jump is taken even on overflow; only the push is dropped.
      pc_d = in;
      if (full) begin
        err_d = 1'b1;
      end else begin
        push_en = 1'b1;
        sp_d    = sp_q + 1'b1;
      end
    end else if (load) begin
      pc_d = in;
    end else if (inc) begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_ADDR;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Stack storage carries no reset; an empty sp makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (!reset && push_en) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

  assign out = pc_q;
  assign err = err_q;

endmodule

// File: tb/tb_my_pc_stack_16.sv
// Directed bench for my_pc_stack_16 (DEPTH=4, RESET_ADDR=0000).

module tb_my_pc_stack_16;
  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        load, inc, call, ret;
  logic [15:0] out;
  logic        full, empty, err;

  int checks;
  int failures;

  my_pc_stack_16 #(.DEPTH(4), .RESET_ADDR(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .load  (load),
    .inc   (inc),
    .call  (call),
    .ret   (ret),
    .out   (out),
    .full  (full),
    .empty (empty),
    .err   (err)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // Drivers: set controls, then advance one edge and sample 1ns later.
  task automatic drive(input logic r, input logic ld, input logic ic,
                       input logic cl, input logic rt, input logic [15:0] addr);
    reset = r; load = ld; inc = ic; call = cl; ret = rt; in = addr;
    @(posedge clk);
    #1;
    reset = 1'b0; load = 1'b0; inc = 1'b0; call = 1'b0; ret = 1'b0;
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic test_reset;
    drive(1, 0, 0, 0, 0, 16'h1234);
    chk16("reset_out", out, 16'h0000);
    chk1("reset_empty", empty, 1'b1);
    chk1("reset_full", full, 1'b0);
    chk1("reset_err", err, 1'b0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 16'h0000);
    chk16("inc_x3_out", out, 16'h0003);
  endtask

  task automatic test_hold_and_load;
    drive(0, 0, 0, 0, 0, 16'hBEEF);
    chk16("hold_out", out, 16'h0003);
    drive(0, 1, 1, 0, 0, 16'h0777);
    chk16("load_over_inc_out", out, 16'h0777);
  endtask

  task automatic test_wrap;
    drive(0, 1, 0, 0, 0, 16'hFFFE);
    chk16("load_fffe_out", out, 16'hFFFE);
    drive(0, 0, 1, 0, 0, 16'h0000);
    chk16("wrap_inc1_out", out, 16'hFFFF);
    drive(0, 0, 1, 0, 0, 16'h0000);
    chk16("wrap_inc2_out", out, 16'h0000);
    chk1("wrap_err", err, 1'b0);
  endtask

  task automatic test_call_ret;
    drive(0, 1, 0, 0, 0, 16'h0010);
    drive(0, 0, 0, 1, 0, 16'h0100);
    chk16("call1_out", out, 16'h0100);
    chk1("call1_empty", empty, 1'b0);
    drive(0, 0, 0, 1, 0, 16'h0200);
    chk16("call2_out", out, 16'h0200);
    drive(0, 0, 0, 0, 1, 16'h0000);
    chk16("ret1_out", out, 16'h0101);
    drive(0, 0, 0, 0, 1, 16'h0000);
    chk16("ret2_out", out, 16'h0011);
    chk1("ret2_empty", empty, 1'b1);
    chk1("call_ret_err", err, 1'b0);
  endtask

  task automatic test_call_wrap;
    drive(0, 1, 0, 0, 0, 16'hFFFF);
    drive(0, 0, 0, 1, 0, 16'h0042);
    chk16("call_at_ffff_out", out, 16'h0042);
    drive(0, 0, 0, 0, 1, 16'h0000);
    chk16("ret_wrapped_addr", out, 16'h0000);
    chk1("call_wrap_empty", empty, 1'b1);
  endtask

  task automatic test_overflow;
    logic [15:0] exp_ret [4];
    exp_ret[0] = 16'h4001; exp_ret[1] = 16'h3001;
    exp_ret[2] = 16'h2001; exp_ret[3] = 16'h1001;
    drive(0, 1, 0, 0, 0, 16'h1000);
    drive(0, 0, 0, 1, 0, 16'h2000);
    drive(0, 0, 0, 1, 0, 16'h3000);
    drive(0, 0, 0, 1, 0, 16'h4000);
    chk1("three_calls_full", full, 1'b0);
    drive(0, 0, 0, 1, 0, 16'h5000);
    chk1("four_calls_full", full, 1'b1);
    chk1("four_calls_err", err, 1'b0);
    drive(0, 0, 0, 1, 0, 16'h0ABC);
    chk16("overflow_out", out, 16'h0ABC);
    chk1("overflow_full", full, 1'b1);
    chk1("overflow_err", err, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 16'h0000);
      chk16($sformatf("lifo_ret%0d", i), out, exp_ret[i]);
      if (i == 0) chk1("after_first_ret_full", full, 1'b0);
    end
    chk1("after_rets_empty", empty, 1'b1);
    chk1("overflow_err_sticky", err, 1'b1);
  endtask

  task automatic test_underflow;
    drive(1, 0, 0, 0, 0, 16'h0000);
    chk1("ufl_pre_err", err, 1'b0);
    drive(0, 0, 0, 0, 1, 16'h0000);
    chk16("ufl_ret_out", out, 16'h0000);
    chk1("ufl_ret_err", err, 1'b1);
    drive(0, 1, 1, 1, 1, 16'h0555);
    chk16("ufl_all_ctrl_out", out, 16'h0000);
    chk1("ufl_all_ctrl_empty", empty, 1'b1);
    chk1("ufl_all_ctrl_err", err, 1'b1);
  endtask

  task automatic test_back_to_back;
    drive(1, 0, 0, 0, 0, 16'h0000);
    drive(0, 1, 0, 0, 0, 16'h0030);
    drive(0, 0, 0, 1, 0, 16'h0300);
    drive(0, 0, 0, 1, 1, 16'h0999);
    chk16("call_ret_same_out", out, 16'h0031);
    chk1("call_ret_same_empty", empty, 1'b1);
    chk1("call_ret_same_err", err, 1'b0);
    drive(0, 0, 1, 0, 0, 16'h0000);
    drive(0, 0, 1, 0, 0, 16'h0000);
    chk16("b2b_inc_out", out, 16'h0033);
  endtask

  task automatic test_reset_mid;
    drive(1, 0, 0, 0, 0, 16'h0000);
    drive(0, 0, 0, 0, 1, 16'h0000);
    drive(0, 0, 0, 1, 0, 16'h0048);
    drive(0, 0, 0, 1, 0, 16'h004F);
    drive(0, 0, 1, 0, 0, 16'h0000);
    chk16("mid_pre_out", out, 16'h0050);
    chk1("mid_pre_err", err, 1'b1);
    chk1("mid_pre_empty", empty, 1'b0);
    drive(1, 0, 0, 1, 0, 16'h0123);
    chk16("mid_reset_out", out, 16'h0000);
    chk1("mid_reset_empty", empty, 1'b1);
    chk1("mid_reset_full", full, 1'b0);
    chk1("mid_reset_err", err, 1'b0);
    drive(0, 0, 0, 0, 1, 16'h0000);
    chk16("mid_post_ret_out", out, 16'h0000);
    chk1("mid_post_ret_err", err, 1'b1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1; load = 1'b0; inc = 1'b0; call = 1'b0; ret = 1'b0; in = 16'h0000;
    @(posedge clk);
    #1;
    test_reset;
    test_hold_and_load;
    test_wrap;
    test_call_ret;
    test_call_wrap;
    test_overflow;
    test_underflow;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
